// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states, primary opcodes and
// instruction field positions used by the fetch stage and its next-PC mux.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_RST,
        ST_FETCH,
        ST_HOLD,
        ST_ERR
    } fetch_state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_COP1 = 6'h11;

    localparam int IMM16_MSB    = 15;
    localparam int IMM16_LSB    = 0;
    localparam int TARGET26_MSB = 25;
    localparam int TARGET26_LSB = 0;
    localparam int TF_BIT       = 16;

    // Branch displacement in bytes: sign-extended word offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: jr > j/jal > taken branch > sequential.
// Purely combinational; only the low 26 instruction bits carry target fields.
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] inst_field,
    input  logic        jump,
    input  logic        jal,
    input  logic        jr,
    input  logic        branch,
    input  logic        nequal,
    input  logic        bclt,
    input  logic        zero,
    input  logic        fp_cond,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic taken;

    assign taken = (branch & (zero ^ nequal)) | (bclt & (fp_cond == inst_field[TF_BIT]));

    always_comb begin
        // NOTE: default assignment first so no path leaves next_pc unassigned (no latch).
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target;
        end else if (jump | jal) begin
            next_pc = {pc_plus4[31:28], inst_field[TARGET26_MSB:TARGET26_LSB], 2'b00};
        end else if (taken) begin
            next_pc = pc_plus4 + branch_offset(inst_field[IMM16_MSB:IMM16_LSB]);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, handshakes with imem, holds the word until retire.
// Define FETCH_MISALIGN_EN to trap misaligned next-PC values instead of masking them.
module inst_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        jump,
    input  logic        jal,
    input  logic        jr,
    input  logic        branch,
    input  logic        nequal,
    input  logic        bclt,
    input  logic        zero,
    input  logic        fp_cond,
    input  logic [31:0] jr_target,
    output logic        fetch_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    fetch_state_t     state;
    logic [31:0]      pc;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc_out + 32'd4;

    next_pc_sel u_next_pc_sel (
        .pc_plus4   (pc_plus4),
        .inst_field (inst[25:0]),
        .jump       (jump),
        .jal        (jal),
        .jr         (jr),
        .branch     (branch),
        .nequal     (nequal),
        .bclt       (bclt),
        .zero       (zero),
        .fp_cond    (fp_cond),
        .jr_target  (jr_target),
        .next_pc    (next_pc)
    );

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RST;
            pc         <= RESET_PC;
            wait_cnt   <= '0;
            imem_req   <= 1'b0;
            inst       <= 32'h0;
            inst_valid <= 1'b0;
            pc_out     <= RESET_PC;
            fetch_err  <= 1'b0;
        end else begin
            case (state)
                ST_RST: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        inst       <= imem_rdata;
                        pc_out     <= pc;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= ST_HOLD;
                    end else if (wait_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        fetch_err <= 1'b1;
                        imem_req  <= 1'b0;
                        state     <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (retire) begin
                        inst_valid <= 1'b0;
                        wait_cnt   <= '0;
`ifdef FETCH_MISALIGN_EN
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            state     <= ST_ERR;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end
`else
                        pc       <= next_pc & ~32'h3;
                        imem_req <= 1'b1;
                        state    <= ST_FETCH;
`endif
                    end
                end
                ST_ERR: begin
                    state <= ST_ERR;
                end
                default: begin
                    state <= ST_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed cases with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_inst_fetch;
    import mips_pkg::*;

    localparam int ACK_TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        retire = 1'b0;
    logic        jump = 1'b0, jal = 1'b0, jr = 1'b0, branch = 1'b0;
    logic        nequal = 1'b0, bclt = 1'b0, zero = 1'b0, fp_cond = 1'b0;
    logic [31:0] jr_target = 32'h0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .retire     (retire),
        .jump       (jump),
        .jal        (jal),
        .jr         (jr),
        .branch     (branch),
        .nequal     (nequal),
        .bclt       (bclt),
        .zero       (zero),
        .fp_cond    (fp_cond),
        .jr_target  (jr_target),
        .fetch_err  (fetch_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    endtask

    // Architectural next-PC rule, written from the ISA description.
    function automatic logic [31:0] ref_next_pc(input logic [31:0] here, input logic [31:0] word,
                                                input bit j, input bit jl, input bit r,
                                                input bit br, input bit ne, input bit bc,
                                                input bit z, input bit fc,
                                                input logic [31:0] tgt);
        logic [31:0] seq;
        bit          taken;
        seq   = here + 32'd4;
        taken = (br && (z != ne)) || (bc && (fc == word[16]));
        if (r) return tgt;
        if (j || jl) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if (taken) return seq + 32'($signed(word[15:0])) * 32'd4;
        return seq;
    endfunction

    typedef struct {
        bit          in_rst;
        bit          req;
        bit          valid;
        bit          err;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc_out;
        int          waits;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.in_rst = 1'b1;
        r.req    = 1'b0;
        r.valid  = 1'b0;
        r.err    = 1'b0;
        r.pc     = 32'h0;
        r.inst   = 32'h0;
        r.pc_out = 32'h0;
        r.waits  = 0;
        return r;
    endfunction

    // One clock of the fetch stage's observable behaviour, from the current inputs.
    function automatic model_t model_step(input model_t c);
        model_t      n;
        logic [31:0] t;
        n = c;
        if (c.in_rst) begin
            n.in_rst = 1'b0;
            n.req    = 1'b1;
        end else if (c.req) begin
            if (imem_ack) begin
                n.req    = 1'b0;
                n.valid  = 1'b1;
                n.inst   = imem_rdata;
                n.pc_out = c.pc;
                n.waits  = 0;
            end else begin
                n.waits = c.waits + 1;
                if (n.waits >= ACK_TIMEOUT) begin
                    n.req = 1'b0;
                    n.err = 1'b1;
                end
            end
        end else if (c.valid && retire) begin
            t = ref_next_pc(c.pc_out, c.inst, jump, jal, jr, branch, nequal, bclt, zero, fp_cond, jr_target);
            n.valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
            if (t[1:0] != 2'b00) begin
                n.err = 1'b1;
            end else begin
                n.pc  = t;
                n.req = 1'b1;
            end
`else
            n.pc  = t & ~32'h3;
            n.req = 1'b1;
`endif
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m);
    end

    always @(negedge clk) begin
        check("imem_req", {31'h0, imem_req}, {31'h0, m.req});
        check("inst_valid", {31'h0, inst_valid}, {31'h0, m.valid});
        check("fetch_err", {31'h0, fetch_err}, {31'h0, m.err});
        check("inst", inst, m.inst);
        check("pc_out", pc_out, m.pc_out);
        check("pc_plus4", pc_plus4, m.pc_out + 32'd4);
        if (m.req || m.in_rst) check("imem_addr", imem_addr, m.pc);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        retire = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; branch = 1'b0;
        nequal = 1'b0; bclt = 1'b0; zero = 1'b0; fp_cond = 1'b0; jr_target = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic fetch_word(input logic [31:0] word, input int waits);
        for (int k = 0; k < waits; k++) begin
            imem_ack = 1'b0;
            tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic retire_with(input bit j, input bit jl, input bit r, input bit br,
                               input bit ne, input bit bc, input bit z, input bit fc,
                               input logic [31:0] tgt);
        jump = j; jal = jl; jr = r; branch = br; nequal = ne; bclt = bc;
        zero = z; fp_cond = fc; jr_target = tgt; retire = 1'b1;
        tick();
        clear_ctrl();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] beq_m2;
        logic [31:0] jal_100;
        beq_m2  = {OP_BEQ, 10'h000, 16'hFFFE};
        jal_100 = {OP_JAL, 26'h000_0100};

        check("model beq taken", ref_next_pc(32'h40, beq_m2, 0, 0, 0, 1, 0, 0, 1, 0, 0), 32'h3C);
        check("model beq not taken", ref_next_pc(32'h40, beq_m2, 0, 0, 0, 1, 0, 0, 0, 0, 0), 32'h44);
        check("model jal", ref_next_pc(32'h1000_0000, jal_100, 0, 1, 0, 0, 0, 0, 0, 0, 0), 32'h1000_0400);
        check("model bclt taken", ref_next_pc(32'h100, 32'h0001_0004, 0, 0, 0, 0, 0, 1, 0, 1, 0), 32'h114);
        check("model bclt not taken", ref_next_pc(32'h100, 32'h0001_0004, 0, 0, 0, 0, 0, 1, 0, 0, 0), 32'h104);
        check("model wrap", ref_next_pc(32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 32'h0);

        #2 rst = 1'b1;
        tick();
        tick();
        check("reset imem_req", {31'h0, imem_req}, 32'h0);
        check("reset imem_addr", imem_addr, 32'h0);
        check("reset inst", inst, 32'h0);
        check("reset inst_valid", {31'h0, inst_valid}, 32'h0);
        check("reset pc_out", pc_out, 32'h0);
        check("reset pc_plus4", pc_plus4, 32'h4);
        check("reset fetch_err", {31'h0, fetch_err}, 32'h0);

        rst = 1'b0;
        tick();
        check("req after release", {31'h0, imem_req}, 32'h1);
        check("addr after release", imem_addr, 32'h0);
        imem_ack = 1'b0;
        tick();
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        check("valid low in ack cycle", {31'h0, inst_valid}, 32'h0);
        tick();
        imem_ack = 1'b0;
        check("valid after ack", {31'h0, inst_valid}, 32'h1);
        check("first pc_out", pc_out, 32'h0);
        check("first inst", inst, 32'h2008_0005);

        retire_with(0, 0, 1, 0, 0, 0, 0, 0, 32'h40);
        check("jr to 0x40", imem_addr, 32'h40);
        fetch_word(beq_m2, 0);
        retire_with(0, 0, 0, 1, 0, 0, 1, 0, 32'h0);
        check("beq taken addr", imem_addr, 32'h3C);
        fetch_word(32'h0, 1);
        retire_with(0, 0, 1, 0, 0, 0, 0, 0, 32'h40);
        fetch_word(beq_m2, 0);
        retire_with(0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
        check("beq not taken addr", imem_addr, 32'h44);

        fetch_word(32'h0, 0);
        retire_with(0, 0, 1, 0, 0, 0, 0, 0, 32'h1000_0000);
        fetch_word(jal_100, 0);
        check("jal pc_plus4", pc_plus4, 32'h1000_0004);
        retire_with(0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        check("jal addr", imem_addr, 32'h1000_0400);

        fetch_word(32'h0, 0);
        retire_with(1, 0, 1, 0, 0, 0, 0, 0, 32'h80);
        check("jr beats jump", imem_addr, 32'h80);

        fetch_word(32'h0, 0);
        retire_with(0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        fetch_word(32'h0, 0);
        check("wrap pc_plus4", pc_plus4, 32'h0);
        retire_with(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        check("wrap addr", imem_addr, 32'h0);

        fetch_word(32'h0, 0);
        retire_with(0, 0, 1, 0, 0, 0, 0, 0, 32'h82);
`ifdef FETCH_MISALIGN_EN
        check("misalign err", {31'h0, fetch_err}, 32'h1);
        check("misalign no req", {31'h0, imem_req}, 32'h0);
        tick();
        check("misalign still no req", {31'h0, imem_req}, 32'h0);
`else
        check("misalign masked addr", imem_addr, 32'h80);
        check("misalign no err", {31'h0, fetch_err}, 32'h0);
`endif

        do_reset();
        for (int k = 0; k < ACK_TIMEOUT - 1; k++) begin
            imem_ack = 1'b0;
            tick();
        end
        check("req before timeout", {31'h0, imem_req}, 32'h1);
        check("no err before timeout", {31'h0, fetch_err}, 32'h0);
        tick();
        check("timeout err", {31'h0, fetch_err}, 32'h1);
        check("timeout req low", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        check("err sticky", {31'h0, fetch_err}, 32'h1);
        check("err ignores ack", {31'h0, inst_valid}, 32'h0);
        rst = 1'b1;
        tick();
        check("rst clears err", {31'h0, fetch_err}, 32'h0);
        rst = 1'b0;
        tick();
        check("restart req", {31'h0, imem_req}, 32'h1);
        check("restart addr", imem_addr, 32'h0);

        imem_ack = 1'b1;
        rst      = 1'b1;
        #1;
        check("req drops on async rst", {31'h0, imem_req}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        imem_ack = 1'b0;
        check("late ack ignored valid", {31'h0, inst_valid}, 32'h0);
        check("late ack ignored req", {31'h0, imem_req}, 32'h1);

        for (int i = 0; i < 3000; i++) begin
            rst        = (fetch_err === 1'b1) || ($urandom_range(0, 499) == 0);
            imem_ack   = ($urandom_range(0, 9) < 4);
            imem_rdata = $urandom;
            retire     = $urandom_range(0, 1);
            jr         = ($urandom_range(0, 7) == 0);
            jump       = ($urandom_range(0, 7) == 0);
            jal        = ($urandom_range(0, 7) == 0);
            branch     = $urandom_range(0, 1);
            nequal     = $urandom_range(0, 1);
            bclt       = ($urandom_range(0, 3) == 0);
            zero       = $urandom_range(0, 1);
            fp_cond    = $urandom_range(0, 1);
            jr_target  = $urandom;
            if ($urandom_range(0, 9) != 0) jr_target[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) jr_target = 32'hFFFF_FFFC;
            tick();
        end
        rst = 1'b0;
        imem_ack = 1'b0;
        clear_ctrl();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the single-cycle MIPS core. It owns the PC and runs a request/acknowledge handshake with instruction memory. It presents the fetched word to the decoder (opcode = inst[31:26], funct = inst[5:0], fmt = inst[25]) and holds it until the core retires it. On retire it computes the next PC from the decoder's Jump/Jal/Jr/Branch/NEqual/Bclt outputs plus the datapath flags, then starts the next fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- ACK_TIMEOUT, 15, maximum cycles spent waiting for imem_ack before fetch aborts with an error.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals PC.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  32  instruction word, sampled when imem_ack=1 in FETCH.
- inst  output  32  held instruction word to the decoder.
- inst_valid  output  1  inst and pc_out are valid for execution.
- pc_out  output  32  address of inst.
- pc_plus4  output  32  pc_out+4; also the Jal link value.
- retire  input  1  core has executed inst this cycle; advance.
- jump, jal, jr, branch, nequal, bclt  input  1 each  decoder control for the held inst.
- zero  input  1  ALU equality flag (rs==rt).
- fp_cond  input  1  FP condition flag.
- jr_target  input  32  rs register value.
- fetch_err  output  1  sticky error flag; cleared only by rst.

## Operation
- States: RST, FETCH, HOLD, ERR.
- RST: entered asynchronously on rst. Leaves to FETCH on the first clock after rst deasserts.
- FETCH: imem_req=1 and imem_addr=PC, both held stable until ack.
  - On imem_ack: latch imem_rdata into inst, pc_out<=PC, go to HOLD.
  - The wait counter increments every FETCH cycle without ack. If it reaches ACK_TIMEOUT, fetch_err<=1 and go to ERR.
- HOLD: inst_valid=1 and imem_req=0. Without retire the stage holds indefinitely. On retire, PC<=next_pc, inst_valid<=0, clear the wait counter, go to FETCH.
- ERR: imem_req=0, inst_valid=0. Exit only via rst.
- next_pc priority (highest first):
  - jr: jr_target.
  - jump or jal: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - Taken branch: pc_plus4 + (sign_extend(inst[15:0]) << 2). A branch is taken when branch & (zero ^ nequal), or when bclt & (fp_cond == inst[16]).
  - Otherwise: pc_plus4.
- All address arithmetic is 32-bit modulo 2^32. PC 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- imem_ack outside FETCH is ignored. retire outside HOLD is ignored.
- rst mid-FETCH: imem_req drops immediately. A late ack in the RST cycle is ignored.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - inst=32'h0 (nop), inst_valid=0
  - pc_out=RESET_PC, pc_plus4=RESET_PC+4
  - fetch_err=0, wait counter 0
- imem_req rises one cycle after rst deasserts.
- Ack in cycle N gives inst_valid=1 in cycle N+1.
- Retire in cycle M gives imem_req=1 with the new address in cycle M+1.
- Minimum loop for a zero-wait memory (ack the same cycle as req) is 2 cycles per instruction.
- All control and flag inputs are sampled only in the retire cycle.

## Configuration
- FETCH_MISALIGN_EN defined:
  - On retire, a next_pc with [1:0]!=0 sets fetch_err and goes to ERR instead of FETCH.
  - No request is ever issued to a misaligned address.
- Undefined: next_pc[1:0] is forced to 2'b00 and no error is raised.

## Structure
- Shared package mips_pkg holds:
  - the fetch state enum;
  - opcode constants: R 6'h00, j 6'h02, jal 6'h03, beq 6'h04, bne 6'h05, COP1 6'h11;
  - the bit-slice positions of the imm16, target26 and tf (inst[16]) fields.
- One combinational sub-module, next_pc_sel, implements the priority mux and target arithmetic. The FSM, counter and registers stay in inst_fetch.

## Test plan
- rst release, memory acks after 2 waits with 32'h2008_0005 → inst_valid rises the cycle after ack; pc_out=0; inst=32'h2008_0005.
- beq with imm 16'hFFFE, zero=1, at PC 32'h40, retire → next imem_addr=32'h3C. Same case with zero=0 → 32'h44.
- jal with target 26'h000_0100 at PC 32'h1000_0000, retire → imem_addr=32'h1000_0400; pc_plus4=32'h1000_0004 during HOLD.
- jr and jump both asserted, jr_target=32'h80 → imem_addr=32'h80 (jr wins).
- No ack for 15 FETCH cycles → fetch_err=1 and imem_req=0 thereafter. Then assert rst → fetch_err=0 and fetch restarts at RESET_PC.
- With FETCH_MISALIGN_EN, jr_target=32'h82 on retire → fetch_err=1 and no request issued. Without the macro → imem_addr=32'h80.
